// File: rtl/control_counter_iter_if.sv
// Handshake bundle between the iteration sequencer and its accumulator/host.
// The sequencer takes the slave view; the environment driving it takes the master view.
interface control_counter_iter_if;
  logic in_accumCalcDoneFlag;
  logic in_enableEntireModule;
  logic op_enableAccumCalc;
  logic op_allItersDoneFlag;

  modport master (
    output in_accumCalcDoneFlag,
    output in_enableEntireModule,
    input  op_enableAccumCalc,
    input  op_allItersDoneFlag
  );

  modport slave (
    input  in_accumCalcDoneFlag,
    input  in_enableEntireModule,
    output op_enableAccumCalc,
    output op_allItersDoneFlag
  );
endinterface

// File: rtl/control_counter_iter.sv
// Sequences NUM_ITERS accumulator iterations, with a one-cycle restart gap between them.
//
// state | meaning
// IDLE  | waiting for enable, count held at 0
// RUN   | accumulator enabled, waiting for its done flag
// GAP   | one-cycle pause that restarts the accumulator
// DONE  | all iterations complete, held until enable drops
module control_counter_iter #(
  parameter int NUM_ITERS = 4,
  parameter int ITER_W    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  control_counter_iter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITERS - 1);

  logic [1:0]        state_q, state_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic              enable_accum_q;
  logic              all_done_q;

  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    // Dropping enable wins over everything, including a done in the same cycle.
    if (!bus.in_enableEntireModule) begin
      state_d    = IDLE;
      iter_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = RUN;
          iter_cnt_d = '0;
        end
        RUN: begin
          if (bus.in_accumCalcDoneFlag) begin
            if (iter_cnt_q == LAST_ITER) begin
              state_d = DONE;
            end else begin
              state_d    = GAP;
              iter_cnt_d = iter_cnt_q + 1'b1;
            end
          end
        end
        GAP:     state_d = RUN;
        DONE:    state_d = DONE;
        default: begin
          state_d    = IDLE;
          iter_cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs are flopped from the next state so they align with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      iter_cnt_q     <= '0;
      enable_accum_q <= 1'b0;
      all_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      iter_cnt_q     <= iter_cnt_d;
      enable_accum_q <= (state_d == RUN);
      all_done_q     <= (state_d == DONE);
    end
  end

  assign bus.op_enableAccumCalc  = enable_accum_q;
  assign bus.op_allItersDoneFlag = all_done_q;

endmodule

// File: tb/tb_control_counter_iter.sv
// Directed bench for the iteration sequencer: a 4-iteration instance and a 1-iteration instance.
module tb_control_counter_iter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  control_counter_iter_if a_if ();
  control_counter_iter_if b_if ();

  control_counter_iter #(.NUM_ITERS(4), .ITER_W(8)) u_dut4 (
    .clock (clk),
    .reset (rst_n),
    .bus   (a_if.slave)
  );

  control_counter_iter #(.NUM_ITERS(1), .ITER_W(8)) u_dut1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic exp_en, input logic exp_done);
    chk({tag, ".en"},   a_if.op_enableAccumCalc,  exp_en);
    chk({tag, ".done"}, a_if.op_allItersDoneFlag, exp_done);
  endtask

  task automatic chk_b(input string tag, input logic exp_en, input logic exp_done);
    chk({tag, ".en"},   b_if.op_enableAccumCalc,  exp_en);
    chk({tag, ".done"}, b_if.op_allItersDoneFlag, exp_done);
  endtask

  // One done pulse on the 4-iteration instance, followed by the 4 cycles before the next pulse.
  task automatic pulse_a(input string tag, input bit last);
    a_if.in_accumCalcDoneFlag = 1'b1;
    step();
    a_if.in_accumCalcDoneFlag = 1'b0;
    if (last) begin
      chk_a({tag, "_final"}, 1'b0, 1'b1);
    end else begin
      chk_a({tag, "_gap"}, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        step();
        chk_a({tag, "_run"}, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic full_run_a(input string tag);
    for (int p = 0; p < 4; p++) pulse_a($sformatf("%s_p%0d", tag, p), (p == 3));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a_if.in_accumCalcDoneFlag  = 1'b0;
    a_if.in_enableEntireModule = 1'b0;
    b_if.in_accumCalcDoneFlag  = 1'b0;
    b_if.in_enableEntireModule = 1'b0;

    #1;
    chk_a("reset_async", 1'b0, 1'b0);
    chk_b("reset_async_n1", 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_a("reset_held", 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    step();
    chk_a("idle_after_release", 1'b0, 1'b0);
    a_if.in_enableEntireModule = 1'b1;
    step();
    chk_a("run_entry", 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_a("run_no_done", 1'b1, 1'b0);
    end

    full_run_a("run1");
    // Done is ignored while DONE holds.
    for (int i = 0; i < 3; i++) begin
      a_if.in_accumCalcDoneFlag = i[0];
      step();
      chk_a("done_hold", 1'b0, 1'b1);
    end
    a_if.in_accumCalcDoneFlag = 1'b0;

    a_if.in_enableEntireModule = 1'b0;
    step();
    chk_a("done_to_idle", 1'b0, 1'b0);
    a_if.in_enableEntireModule = 1'b1;
    step();
    chk_a("rerun_entry", 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_a("rerun_run", 1'b1, 1'b0);
    end
    full_run_a("run2");

    // Abort: done and enable drop in the same cycle, one iteration into a run.
    a_if.in_enableEntireModule = 1'b0;
    step();
    a_if.in_enableEntireModule = 1'b1;
    step();
    chk_a("abort_entry", 1'b1, 1'b0);
    pulse_a("abort_p0", 1'b0);
    a_if.in_accumCalcDoneFlag  = 1'b1;
    a_if.in_enableEntireModule = 1'b0;
    step();
    a_if.in_accumCalcDoneFlag  = 1'b0;
    chk_a("abort_same_cycle", 1'b0, 1'b0);
    step();
    chk_a("abort_stays_idle", 1'b0, 1'b0);
    a_if.in_enableEntireModule = 1'b1;
    step();
    chk_a("post_abort_entry", 1'b1, 1'b0);
    full_run_a("run3");

    // Async reset pulse mid-RUN, between clock edges.
    a_if.in_enableEntireModule = 1'b0;
    step();
    a_if.in_enableEntireModule = 1'b1;
    step();
    pulse_a("rst_p0", 1'b0);
    chk_a("rst_pre", 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("rst_async_mid_run", 1'b0, 1'b0);
    a_if.in_enableEntireModule = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk_a("rst_idle", 1'b0, 1'b0);
    a_if.in_enableEntireModule = 1'b1;
    step();
    chk_a("post_rst_entry", 1'b1, 1'b0);
    full_run_a("run4");

    // NUM_ITERS=1: first done goes straight to DONE.
    b_if.in_enableEntireModule = 1'b1;
    step();
    chk_b("n1_entry", 1'b1, 1'b0);
    step();
    chk_b("n1_run", 1'b1, 1'b0);
    b_if.in_accumCalcDoneFlag = 1'b1;
    step();
    b_if.in_accumCalcDoneFlag = 1'b0;
    chk_b("n1_done", 1'b0, 1'b1);
    step();
    chk_b("n1_done_hold", 1'b0, 1'b1);
    b_if.in_enableEntireModule = 1'b0;
    step();
    chk_b("n1_idle", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_counter_iter.md
CONTROL_COUNTER_ITER -- requirements
Module: control_counter_iter

Interface
REQ-001 Parameter NUM_ITERS, default 4: total accumulation iterations per run; legal range 1..(2^ITER_W - 1).
REQ-002 Parameter ITER_W, default 8: width of the internal iteration counter in bits.
REQ-003 Port clock  input  1: single system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port in_accumCalcDoneFlag  input  1: accumulator signals completion of one iteration; sampled on the rising edge.
REQ-006 Port in_enableEntireModule  input  1: level enable for the whole iteration sequence; 0 aborts and returns the block to idle.
REQ-007 Port op_enableAccumCalc  output  1: enable driven to the accumulator; high while an iteration is in progress.
REQ-008 Port op_allItersDoneFlag  output  1: high once all NUM_ITERS iterations have completed.

Function
REQ-009 Outputs SHALL be registered Moore outputs decoded from state only, with no combinational input-to-output path.
REQ-010 FSM states SHALL be IDLE, RUN, GAP and DONE.
REQ-011 Iteration counter iter_cnt SHALL be ITER_W bits wide, unsigned.
REQ-012 IDLE: both outputs 0 and iter_cnt held at 0.
REQ-012a IDLE -> RUN on the rising edge where in_enableEntireModule=1; otherwise remain in IDLE.
REQ-013 RUN: op_enableAccumCalc=1 and op_allItersDoneFlag=0.
REQ-014 RUN with done=1 and iter_cnt==NUM_ITERS-1 -> DONE; iter_cnt unchanged.
REQ-015 RUN with done=1 and iter_cnt<NUM_ITERS-1 -> GAP; iter_cnt incremented by 1.
REQ-016 RUN with done=0 -> remain in RUN.
REQ-017 GAP: both outputs 0 for exactly one cycle, then unconditionally -> RUN (if enable is still 1); this restarts the accumulator.
REQ-018 DONE: op_allItersDoneFlag=1 and op_enableAccumCalc=0.
REQ-018a DONE SHALL be held while in_enableEntireModule=1.
REQ-018b DONE -> IDLE with iter_cnt cleared when in_enableEntireModule=0.
REQ-019 in_accumCalcDoneFlag SHALL be ignored in IDLE, GAP and DONE.
REQ-019a A done held high across several RUN cycles counts once per RUN entry, because RUN always leaves on the first sampled done.
REQ-020 in_enableEntireModule=0 in any state SHALL force IDLE on the next rising edge and clear iter_cnt.
REQ-020a Enable deassertion SHALL take priority over a simultaneous done.
REQ-021 Latency: op_enableAccumCalc rises 1 cycle after the edge that samples enable=1.
REQ-021a Latency: op_allItersDoneFlag rises 1 cycle after the edge that samples the final done.
REQ-022 NUM_ITERS=1: the first done in RUN SHALL go directly to DONE without visiting GAP.

Reset
REQ-023 reset=0 SHALL immediately, independent of clock, force state=IDLE, iter_cnt=0, op_enableAccumCalc=0 and op_allItersDoneFlag=0.
REQ-024 Reset asserted mid-iteration or in DONE SHALL abort the sequence.
REQ-024a After reset release the block SHALL restart from IDLE, with no residual count.
REQ-025 After reset is released, the first transition SHALL occur on the first rising edge with in_enableEntireModule=1.

Verification
REQ-026 Reset held low 2 cycles with enable=0 -> both outputs 0 throughout; state IDLE.
REQ-027 Release reset; enable=1 at cycle 2; done=0 for 10 cycles -> op_enableAccumCalc=1 from cycle 3 onward; op_allItersDoneFlag stays 0.
REQ-028 NUM_ITERS=4 with four 1-cycle done pulses, each spaced 5 cycles apart:
- op_enableAccumCalc drops for exactly one GAP cycle after each of the first three pulses.
- After the fourth pulse, op_allItersDoneFlag=1 and op_enableAccumCalc=0.
- Both hold while enable=1.
REQ-029 In DONE, drop enable -> next cycle both outputs 0.
REQ-029a Re-raise enable -> a fresh 4-iteration run starting with iter_cnt=0.
REQ-030 Abort cases:
- done=1 and enable=0 in the same cycle during RUN -> IDLE, no count, no DONE.
- Async reset pulse mid-RUN -> outputs 0 immediately, without waiting for a clock edge.
REQ-031 NUM_ITERS=1: single done pulse in RUN -> DONE one cycle later, with no GAP cycle observed.
